fetch_ctrl: RTL and testbench

Sequential fetch controller for the single-cycle core. It owns the architectural PC register and fetches each instruction from instruction memory over a req/ack handshake. It hands the instruction to decode over a valid/ready handshake, then loads the next PC produced by the combinational next-PC logic. It also implements halt/resume, so the next-PC logic stays purely combinational.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_ctrl_if.sv | 37 +++
 rtl/fetch_perf_cnt.sv | 39 +++
 rtl/fetch_ctrl.sv | 127 ++++++++++++
 tb/tb_fetch_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch controller
//
// Contents:
//   fetch_state_e    : controller states (IDLE, REQ, HOLD, HALT)
//   DEFAULT_RESET_PC : PC loaded on reset unless the top overrides it
//   PERF_W           : width of the optional performance counters
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_e;

    localparam int unsigned DEFAULT_RESET_PC = 0;
    localparam int          PERF_W           = 32;

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - fetch controller bus: imem req/ack, decode valid/ready, next-PC
//
// Signals:
//   imem_req/imem_addr/imem_ack/imem_rdata : instruction-memory handshake
//   instr_valid/instr/instr_pc/instr_ready : hand-off to decode
//   next_pc/halt/resume                    : sequencing inputs from next-PC logic
//   pc                                     : architectural PC register
// Modports:
//   master : the fetch controller side
//   slave  : memory / decode / next-PC side
interface fetch_ctrl_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready;
    logic [ADDR_W-1:0]  next_pc;
    logic               halt;
    logic               resume;
    logic [ADDR_W-1:0]  pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, pc,
        input  imem_ack, imem_rdata, instr_ready, next_pc, halt, resume
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc,
        output imem_ack, imem_rdata, instr_ready, next_pc, halt, resume
    );
endinterface

// File: rtl/fetch_perf_cnt.sv
// rtl/fetch_perf_cnt.sv - saturating event counter
//
// Ports:
//   clk   : clock
//   reset : synchronous active-high clear
//   inc   : count one event this cycle
//   count : current value, sticks at all-ones
module fetch_perf_cnt
    import fetch_pkg::*;
#(
    parameter int W = PERF_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - sequential fetch controller owning the architectural PC
//
// Ports:
//   clk   : clock, all state on rising edge
//   reset : synchronous active-high
//   bus   : fetch_ctrl_if.master (imem req/ack, decode valid/ready, next_pc/halt/resume, pc)
//   perf_retired, perf_stall : present only when FETCH_CTRL_PERF_EN is defined
//
// Optional feature macro: FETCH_CTRL_PERF_EN (saturating retired/stall counters).
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              ADDR_W   = 16,
    parameter int              INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    fetch_ctrl_if.master      bus
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_retired,
    output logic [PERF_W-1:0] perf_stall
`endif
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               imem_req_q, imem_req_d;
    logic               instr_valid_q, instr_valid_d;

    // Ack only counts while a request is actually outstanding; accept only
    // while an instruction is actually offered.
    logic ack_taken;
    logic accept;

    assign ack_taken = (state_q == ST_REQ) && bus.imem_ack;
    assign accept    = instr_valid_q && bus.instr_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (ack_taken) begin
                    instr_d    = bus.imem_rdata;
                    instr_pc_d = pc_q;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    pc_d    = bus.next_pc;
                    // resume is not looked at here, so halt wins when both are high
                    state_d = bus.halt ? ST_HALT : ST_REQ;
                end
            end
            ST_HALT: begin
                if (bus.resume) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered: derive them from the state being entered.
        imem_req_d    = (state_d == ST_REQ);
        instr_valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.pc          = pc_q;

`ifdef FETCH_CTRL_PERF_EN
    logic stall_evt;

    assign stall_evt = ((state_q == ST_REQ)  && !bus.imem_ack) ||
                       ((state_q == ST_HOLD) && !bus.instr_ready);

    fetch_perf_cnt #(.W(PERF_W)) u_retired (
        .clk   (clk),
        .reset (reset),
        .inc   (accept),
        .count (perf_retired)
    );

    fetch_perf_cnt #(.W(PERF_W)) u_stall (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_evt),
        .count (perf_stall)
    );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    fetch_ctrl_if #(.ADDR_W(16), .INSTR_W(16)) bus ();

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_retired;
    logic [31:0] perf_stall;
`endif

    fetch_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus)
`ifdef FETCH_CTRL_PERF_EN
        ,
        .perf_retired (perf_retired),
        .perf_stall   (perf_stall)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] next_pc;
        logic        exp_req;
        logic [15:0] exp_addr;
        logic        exp_valid;
        logic [15:0] exp_ipc;
        logic [15:0] exp_instr;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic ack, input logic [15:0] rdata, input logic ready,
                       input logic [15:0] npc, input logic hlt, input logic res);
        bus.imem_ack    = ack;
        bus.imem_rdata  = rdata;
        bus.instr_ready = ready;
        bus.next_pc     = npc;
        bus.halt        = hlt;
        bus.resume      = res;
    endtask

    // Leaves the bench in cycle 0 (first cycle with reset low).
    task automatic do_reset();
        reset = 1'b1;
        drv(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic vec_t mk(logic [15:0] npc, logic rq, logic [15:0] addr,
                                logic vl, logic [15:0] ipc, logic [15:0] ins);
        vec_t v;
        v.next_pc = npc; v.exp_req = rq; v.exp_addr = addr;
        v.exp_valid = vl; v.exp_ipc = ipc; v.exp_instr = ins;
        return v;
    endfunction

    // Random-phase reference state, expressed in terms of observed handshakes.
    logic        exp_req, exp_valid, halted, from_idle;
    logic        prev_req, prev_ack, prev_valid, prev_ready, prev_halt, prev_resume;
    logic [15:0] prev_next_pc, exp_pc, exp_ipc, exp_instr;
    logic        r_ack, r_ready, r_halt, r_resume;
    logic [15:0] r_rdata, r_npc;
    int          acc_cnt, stall_cnt;

    initial begin
        checks   = 0;
        failures = 0;

        tbl[0] = mk(16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        tbl[1] = mk(16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        tbl[2] = mk(16'h0001, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h1001);
        tbl[3] = mk(16'h0001, 1'b1, 16'h0001, 1'b0, 16'h0000, 16'h0000);
        tbl[4] = mk(16'h0002, 1'b0, 16'h0000, 1'b1, 16'h0001, 16'h1003);
        tbl[5] = mk(16'h0002, 1'b1, 16'h0002, 1'b0, 16'h0000, 16'h0000);
        tbl[6] = mk(16'h0003, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h1005);
        tbl[7] = mk(16'h0003, 1'b1, 16'h0003, 1'b0, 16'h0000, 16'h0000);

        // ---- zero-wait memory, decode always ready ----
        do_reset();
        chk("reset_pc", 32'(bus.pc), 32'h0);
        chk("reset_instr", 32'(bus.instr), 32'h0);
        chk("reset_instr_pc", 32'(bus.instr_pc), 32'h0);
`ifdef FETCH_CTRL_PERF_EN
        chk("reset_perf_retired", perf_retired, 32'h0);
        chk("reset_perf_stall", perf_stall, 32'h0);
`endif
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tbl%0d_req", i), 32'(bus.imem_req), 32'(tbl[i].exp_req));
            chk($sformatf("tbl%0d_valid", i), 32'(bus.instr_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_req)
                chk($sformatf("tbl%0d_addr", i), 32'(bus.imem_addr), 32'(tbl[i].exp_addr));
            if (tbl[i].exp_valid) begin
                chk($sformatf("tbl%0d_instr_pc", i), 32'(bus.instr_pc), 32'(tbl[i].exp_ipc));
                chk($sformatf("tbl%0d_instr", i), 32'(bus.instr), 32'(tbl[i].exp_instr));
            end
            drv(1'b1, 16'h1000 + 16'(i), 1'b1, tbl[i].next_pc, 1'b0, 1'b0);
            tick();
        end

        // ---- late ack, decode stall, halt/resume, reset mid-REQ ----
        do_reset();
        chk("seq_c0_req", 32'(bus.imem_req), 32'h0);
        drv(1'b1, 16'h9999, 1'b0, 16'h0, 1'b0, 1'b0);
        tick();
        chk("seq_c1_addr", 32'(bus.imem_addr), 32'h0);
        drv(1'b1, 16'h1111, 1'b0, 16'h0, 1'b0, 1'b0);
        tick();
        chk("seq_c2_valid", 32'(bus.instr_valid), 32'h1);
        drv(1'b0, 16'h0, 1'b1, 16'h0005, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("late_wait%0d_req", k), 32'(bus.imem_req), 32'h1);
            chk($sformatf("late_wait%0d_addr", k), 32'(bus.imem_addr), 32'h0005);
            drv(1'b0, 16'hDEAD, 1'b1, 16'h0, 1'b0, 1'b0);
            tick();
        end
        chk("late_ack_addr", 32'(bus.imem_addr), 32'h0005);
        drv(1'b1, 16'hBEEF, 1'b0, 16'h0, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("stall%0d_valid", k), 32'(bus.instr_valid), 32'h1);
            chk($sformatf("stall%0d_req", k), 32'(bus.imem_req), 32'h0);
            chk($sformatf("stall%0d_instr", k), 32'(bus.instr), 32'hBEEF);
            chk($sformatf("stall%0d_instr_pc", k), 32'(bus.instr_pc), 32'h0005);
            drv(1'b1, 16'h4444, 1'b0, 16'h0077, 1'b1, 1'b0);
            tick();
        end
        chk("stall_end_valid", 32'(bus.instr_valid), 32'h1);
        drv(1'b0, 16'h0, 1'b1, 16'h0040, 1'b0, 1'b0);
        tick();
        chk("jump_req", 32'(bus.imem_req), 32'h1);
        chk("jump_addr", 32'(bus.imem_addr), 32'h0040);
        drv(1'b1, 16'h1234, 1'b0, 16'h0, 1'b0, 1'b0);
        tick();
        chk("halt_hold_instr", 32'(bus.instr), 32'h1234);
        chk("halt_hold_instr_pc", 32'(bus.instr_pc), 32'h0040);
        // halt and resume together: halt wins
        drv(1'b0, 16'h0, 1'b1, 16'h0010, 1'b1, 1'b1);
        tick();
`ifdef FETCH_CTRL_PERF_EN
        chk("perf_retired_seq", perf_retired, 32'd3);
        chk("perf_stall_seq", perf_stall, 32'd7);
`endif
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("halt%0d_req", k), 32'(bus.imem_req), 32'h0);
            chk($sformatf("halt%0d_valid", k), 32'(bus.instr_valid), 32'h0);
            chk($sformatf("halt%0d_pc", k), 32'(bus.pc), 32'h0010);
            drv(1'b1, 16'h5555, 1'b1, 16'h0066, 1'b0, (k == 2));
            tick();
        end
        chk("resume_req", 32'(bus.imem_req), 32'h1);
        chk("resume_addr", 32'(bus.imem_addr), 32'h0010);
        reset = 1'b1;
        drv(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        drv(1'b1, 16'hABCD, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("rst_mid_req", 32'(bus.imem_req), 32'h0);
        chk("rst_mid_valid", 32'(bus.instr_valid), 32'h0);
        chk("rst_mid_pc", 32'(bus.pc), 32'h0);
        chk("rst_mid_instr", 32'(bus.instr), 32'h0);
`ifdef FETCH_CTRL_PERF_EN
        chk("rst_mid_perf_retired", perf_retired, 32'h0);
        chk("rst_mid_perf_stall", perf_stall, 32'h0);
`endif
        tick();
        chk("rst_first_req", 32'(bus.imem_req), 32'h1);
        chk("rst_first_addr", 32'(bus.imem_addr), 32'h0);
        chk("rst_ack_ignored", 32'(bus.instr_valid), 32'h0);

        // ---- randomized run against a handshake-level model ----
        do_reset();
        exp_pc = 16'h0; exp_ipc = 16'h0; exp_instr = 16'h0;
        from_idle = 1'b1; halted = 1'b0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0;
        prev_halt = 1'b0; prev_resume = 1'b0; prev_next_pc = 16'h0;
        exp_req = 1'b0; exp_valid = 1'b0;
        acc_cnt = 0; stall_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c == 0) begin
                exp_req = 1'b0; exp_valid = 1'b0;
            end else if (from_idle) begin
                exp_req = 1'b1; exp_valid = 1'b0; from_idle = 1'b0;
            end else if (prev_req) begin
                exp_req = !prev_ack; exp_valid = prev_ack;
            end else if (prev_valid) begin
                if (!prev_ready) begin
                    exp_req = 1'b0; exp_valid = 1'b1;
                end else begin
                    exp_pc = prev_next_pc; exp_valid = 1'b0;
                    exp_req = !prev_halt; halted = prev_halt;
                end
            end else if (halted) begin
                exp_req = prev_resume; exp_valid = 1'b0; halted = !prev_resume;
            end

            chk("rnd_req", 32'(bus.imem_req), 32'(exp_req));
            chk("rnd_valid", 32'(bus.instr_valid), 32'(exp_valid));
            chk("rnd_pc", 32'(bus.pc), 32'(exp_pc));
            if (exp_req) chk("rnd_addr", 32'(bus.imem_addr), 32'(exp_pc));
            if (exp_valid) begin
                chk("rnd_instr", 32'(bus.instr), 32'(exp_instr));
                chk("rnd_instr_pc", 32'(bus.instr_pc), 32'(exp_ipc));
            end

            r_ack    = ($urandom_range(0, 2) == 0);
            r_rdata  = 16'($urandom);
            r_ready  = ($urandom_range(0, 2) != 0);
            r_npc    = ($urandom_range(0, 3) == 0) ? exp_ipc : 16'($urandom);
            r_halt   = ($urandom_range(0, 7) == 0);
            r_resume = ($urandom_range(0, 3) == 0);
            drv(r_ack, r_rdata, r_ready, r_npc, r_halt, r_resume);

            if (exp_req && r_ack) begin
                exp_instr = r_rdata;
                exp_ipc   = exp_pc;
            end
            if (exp_req && !r_ack) stall_cnt++;
            if (exp_valid && !r_ready) stall_cnt++;
            if (exp_valid && r_ready) acc_cnt++;

            prev_req = exp_req; prev_ack = r_ack; prev_valid = exp_valid;
            prev_ready = r_ready; prev_halt = r_halt; prev_resume = r_resume;
            prev_next_pc = r_npc;
            tick();
        end
`ifdef FETCH_CTRL_PERF_EN
        chk("rnd_perf_retired", perf_retired, 32'(acc_cnt));
        chk("rnd_perf_stall", perf_stall, 32'(stall_cnt));
        do_reset();
        chk("rnd_perf_retired_clr", perf_retired, 32'h0);
        chk("rnd_perf_stall_clr", perf_stall, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
